aes128_engine: RTL and testbench
================================

# aes128_engine

Iterative AES-128 block engine with a per-block encrypt/decrypt mode select, valid/ready handshakes on both sides, and an optional expanded-key cache. When consecutive requests use the same key, the cache skips key expansion. It is the next-generation replacement for the decrypt-only core. It sits between the host-side data buffer and the output packer, and reuses the existing SBox/InvSBox, ShiftRow/InvShiftRow, MixColumn/InvMixColumn and KeySchedule (Kin, RC, Kout) leaf modules.

## Interface
Parameters:
- KEY_CACHE, 1, 1 = keep the expanded key schedule and skip expansion on a key match; 0 = expand on every block.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  engine can accept a request
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- key  in  128  cipher key; sampled on accept
- din  in  128  input block; sampled on accept
- key_flush  in  1  single-cycle pulse that invalidates the cache
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- dout  out  128  result block
- key_hit  out  1  result was produced with cached keys; qualified by out_valid

## Operation
- Storage: round-key array K0..K10 (11 x 128 bits), cache tag (128 bits), cache_valid, state register (128 bits), and latched mode.
- FSM states: IDLE, EXPAND, ADD, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: state <= din; mode is latched.
  - hit = KEY_CACHE & cache_valid & (key == tag) & !key_flush.
  - On a hit, go to ADD.
  - On a miss, write K0 <= key and tag <= key, clear cache_valid, and go to EXPAND.
- EXPAND:
  - 10 cycles; cycle i (1..10) writes Ki = KeySchedule(K(i-1), RCi).
  - RC sequence: 01,02,04,08,10,20,40,80,1b,36.
  - After K10, set cache_valid and go to ADD.
- ADD (1 cycle): state ^= K0 when encrypting, K10 when decrypting.
- ROUND:
  - 10 cycles, round counter r = 1..10.
  - Encrypt, round r: SubBytes, ShiftRows, MixColumns (skipped when r = 10), then XOR Kr.
  - Decrypt, round r: InvShiftRows, InvSubBytes, XOR K(10-r), then InvMixColumns (skipped when r = 10).
  - After r = 10, go to DONE.
- DONE:
  - out_valid = 1 and dout = state.
  - On out_ready, go to IDLE.
- in_ready is 1 only in IDLE, so there is no overlap between blocks.
- dout reads 0 whenever out_valid = 0.
- key_flush:
  - Clears cache_valid in any state.
  - If asserted in the same cycle as an accept, that block is a miss.
  - During EXPAND, it also cancels the cache_valid set at the end of expansion.
  - It never affects the block currently in flight.
- KEY_CACHE = 0: hit is forced to 0 and key_hit is always 0.

## Timing
- Reset values: in_ready 0 while rst is high and 1 from the first edge after release (FSM in IDLE); out_valid 0; dout 0; key_hit 0; cache_valid 0; all K and state registers 0.
- Let accept edge = E0.
  - Miss: EXPAND E1..E10, ADD E11, ROUND E12..E21; out_valid high after E21, i.e. a latency of 21 cycles.
  - Hit: ADD E1, ROUND E2..E11; a latency of 11 cycles.
- Output stability: dout, key_hit and out_valid hold stable while out_valid & !out_ready.
- out_valid drops on the edge where out_ready is sampled high. in_ready rises at that same edge.
- Reset asserted mid-operation:
  - Abort immediately (asynchronous).
  - The cache is invalidated, so the next block is a miss.
  - No partial result appears on dout.
- Changes on in_valid, key or din outside the accept cycle are ignored.

## Test plan
- Cold encrypt: key 000102030405060708090a0b0c0d0e0f, din 00112233445566778899aabbccddeeff, mode 0 -> dout 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 21 cycles after accept, key_hit 0.
- Warm decrypt, same key: din 69c4e0d86a7b0430d8cdb78070b4c55a, mode 1 -> dout 00112233445566778899aabbccddeeff, latency 11, key_hit 1.
- Key change: key 2b7e151628aed2a6abf7158809cf4f3c, din 3243f6a8885a308d313198a2e0370734, mode 0 -> dout 3925841d02dc09fbdc118597196a0b32, latency 21, key_hit 0. Then decrypt it back with latency 11.
- Backpressure: hold out_ready low for 5 cycles after out_valid -> dout and key_hit stable, in_ready 0 throughout. Raise out_ready -> in_ready 1 on the next cycle, and the next request is accepted.
- Reset at E6 of a hit block -> out_valid 0 and dout 0 immediately, in_ready 1 after release. The same key then re-sent gives latency 21 and key_hit 0.
- key_flush pulsed together with an accept (same key as cache) -> latency 21, key_hit 0. With KEY_CACHE = 0, every block has latency 21.

Source files
------------

// File: rtl/aes128_engine.sv
// Iterative AES-128 encrypt/decrypt engine, one block in flight, with an optional
// expanded-key cache that skips key expansion when the key repeats.
module aes128_engine #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [127:0] din,
    input  logic         key_flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         key_hit
);
    typedef enum logic [2:0] {IDLE, EXPAND, ADD, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(a3, a3);
        a12  = gf_mul(a12, a12);
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int n;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                n = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*n) -: 8];
            end
        end
        return o;
    endfunction

    // InvMixColumns is a pre-multiply by {04}(a0^a2)/(a1^a3) followed by MixColumns
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3, t, u, v;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (inv) begin
                u  = xtime(xtime(a0 ^ a2));
                v  = xtime(xtime(a1 ^ a3));
                a0 = a0 ^ u;
                a1 = a1 ^ v;
                a2 = a2 ^ u;
                a3 = a3 ^ v;
            end
            t = a0 ^ a1 ^ a2 ^ a3;
            o[127-32*c -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            o[119-32*c -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            o[111-32*c -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            o[103-32*c -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_sched(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       fsm;
    logic [127:0] rk [0:10];
    logic [127:0] tag;
    logic [127:0] st;
    logic         cache_valid;
    logic         mode_q;
    logic         hit_q;
    logic         flush_seen;
    logic [3:0]   rnd;
    logic         hit;
    logic [127:0] key_next;
    logic [127:0] enc_out;
    logic [127:0] dec_out;
    logic [127:0] round_out;

    assign hit      = (KEY_CACHE != 0) && cache_valid && (key == tag) && !key_flush;
    // rnd stays within 1..10 in every state, so rnd-1 is always a legal index
    assign key_next = key_sched(rk[rnd - 4'd1], rcon(rnd));

    always_comb begin
        enc_out = shift_rows(sub_bytes(st, 1'b0), 1'b0);
        if (rnd != 4'd10) enc_out = mix_columns(enc_out, 1'b0);
        enc_out = enc_out ^ rk[rnd];
        dec_out = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk[4'd10 - rnd];
        if (rnd != 4'd10) dec_out = mix_columns(dec_out, 1'b1);
        round_out = mode_q ? dec_out : enc_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            dout        <= '0;
            key_hit     <= 1'b0;
            cache_valid <= 1'b0;
            tag         <= '0;
            st          <= '0;
            mode_q      <= 1'b0;
            hit_q       <= 1'b0;
            flush_seen  <= 1'b0;
            rnd         <= 4'd1;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            if (key_flush) cache_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        st       <= din;
                        mode_q   <= mode;
                        rnd      <= 4'd1;
                        hit_q    <= hit;
                        if (hit) begin
                            fsm <= ADD;
                        end else begin
                            rk[0]       <= key;
                            tag         <= key;
                            cache_valid <= 1'b0;
                            flush_seen  <= 1'b0;
                            fsm         <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    rk[rnd] <= key_next;
                    if (key_flush) flush_seen <= 1'b1;
                    if (rnd == 4'd10) begin
                        rnd         <= 4'd1;
                        cache_valid <= !(flush_seen || key_flush);
                        fsm         <= ADD;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                ADD: begin
                    st  <= st ^ (mode_q ? rk[10] : rk[0]);
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= round_out;
                    if (rnd == 4'd10) begin
                        rnd       <= 4'd1;
                        out_valid <= 1'b1;
                        dout      <= round_out;
                        key_hit   <= hit_q;
                        fsm       <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        dout      <= '0;
                        key_hit   <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_engine.sv
// Bench for aes128_engine: directed known-answer blocks plus random blocks checked
// against a byte-array AES-128 model with a simple key-cache model.
module tb_aes128_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, mode, key_flush, out_ready, sel;
    logic [127:0] key, din;
    logic         a_in_valid, a_in_ready, a_out_valid, a_key_hit;
    logic         b_in_valid, b_in_ready, b_out_valid, b_key_hit;
    logic [127:0] a_dout, b_dout;
    logic         o_in_ready, o_out_valid, o_key_hit;
    logic [127:0] o_dout;

    assign a_in_valid  = in_valid & !sel;
    assign b_in_valid  = in_valid & sel;
    assign o_in_ready  = sel ? b_in_ready : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_key_hit   = sel ? b_key_hit : a_key_hit;
    assign o_dout      = sel ? b_dout : a_dout;

    aes128_engine #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .mode(mode),
        .key(key), .din(din), .key_flush(key_flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .dout(a_dout), .key_hit(a_key_hit)
    );

    aes128_engine #(.KEY_CACHE(0)) dut_nc (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(mode),
        .key(key), .din(din), .key_flush(key_flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .dout(b_dout), .key_hit(b_key_hit)
    );

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    bit           cache_ok = 1'b0;
    logic [127:0] ckey = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] col, input bit inv);
        logic [7:0]  cf [4];
        logic [7:0]  a [4];
        logic [7:0]  acc;
        logic [31:0] o;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j - row + 4) % 4], a[j]);
            o[31-8*row -: 8] = acc;
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] blk, input bit dec);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, ti;
        logic [31:0]  col;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127-8*i -: 8];
            s[i] = blk[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                ti = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[ti];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        if (!dec) begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
            for (int r = 1; r <= 10; r++) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) t[row+4*c] = sb[s[row+4*((c+row)%4)]];
                for (int c = 0; c < 4; c++) begin
                    col = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                    if (r < 10) col = mixcol(col, 1'b0);
                    for (int j = 0; j < 4; j++) s[4*c+j] = col[31-8*j -: 8] ^ w[16*r+4*c+j];
                end
            end
        end else begin
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[160+i];
            for (int r = 9; r >= 0; r--) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) t[row+4*((c+row)%4)] = isb[s[row+4*c]];
                for (int c = 0; c < 4; c++) begin
                    col = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
                    for (int j = 0; j < 4; j++) col[31-8*j -: 8] = col[31-8*j -: 8] ^ w[16*r+4*c+j];
                    if (r > 0) col = mixcol(col, 1'b1);
                    for (int j = 0; j < 4; j++) s[4*c+j] = col[31-8*j -: 8];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // fc >= 1 pulses key_flush in the cycle after edge E(fc); fa flushes in the accept cycle
    task automatic run_block(input logic m, input logic [127:0] k, input logic [127:0] d,
                             input logic [127:0] exp_out, input int fc, input bit fa,
                             input int bp, input string tag);
        int   lat, guard;
        logic exp_hit;
        bit   bad;
        exp_hit = !sel && cache_ok && (k == ckey) && !fa;
        @(negedge clk);
        in_valid = 1'b1; mode = m; key = k; din = d; key_flush = fa;
        guard = 0;
        while (!o_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 128'(o_in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0; key_flush = 1'b0; mode = ~m;
        key = {$urandom, $urandom, $urandom, $urandom};
        din = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        bad = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            #1 key_flush = (lat == fc);
            @(negedge clk);
            if (!o_out_valid && (o_dout !== '0 || o_in_ready !== 1'b0)) bad = 1'b1;
        end while (!o_out_valid && lat < 40);
        key_flush = 1'b0;
        check({tag, "_latency"}, 128'(lat), exp_hit ? 128'(11) : 128'(21));
        check({tag, "_dout"}, o_dout, exp_out);
        check({tag, "_key_hit"}, 128'(o_key_hit), 128'(exp_hit));
        check({tag, "_busy_outputs"}, 128'(bad), 128'(0));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bp_valid"}, 128'(o_out_valid), 128'(1));
            check({tag, "_bp_dout"}, o_dout, exp_out);
            check({tag, "_bp_hit"}, 128'(o_key_hit), 128'(exp_hit));
            check({tag, "_bp_in_ready"}, 128'(o_in_ready), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rel_valid"}, 128'(o_out_valid), 128'(0));
        check({tag, "_rel_in_ready"}, 128'(o_in_ready), 128'(1));
        check({tag, "_rel_dout"}, o_dout, 128'(0));
        if (!sel) begin
            if (!exp_hit) ckey = k;
            cache_ok = (fc < 1);
        end
    endtask

    initial begin
        logic [7:0]   inv;
        logic [127:0] rk, rd;
        logic         rm;
        int           pick;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; key_flush = 1'b0; out_ready = 1'b0; sel = 1'b0;
        key = '0; din = '0;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);

        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(a_in_ready), 128'(0));
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_dout", a_dout, 128'(0));
        check("rst_key_hit", 128'(a_key_hit), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rel_in_ready", 128'(a_in_ready), 128'(1));

        run_block(1'b0, K1, P1, C1, -1, 1'b0, 0, "cold_enc");
        run_block(1'b1, K1, C1, P1, -1, 1'b0, 0, "warm_dec");
        run_block(1'b0, K2, P2, C2, -1, 1'b0, 0, "key_change");
        run_block(1'b1, K2, C2, P2, -1, 1'b0, 5, "bp_dec");

        // Reset at E6 of a cache-hit block
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b0; key = K2; din = P2;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(a_out_valid), 128'(0));
        check("midrst_dout", a_dout, 128'(0));
        check("midrst_in_ready", 128'(a_in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        cache_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rel_in_ready", 128'(a_in_ready), 128'(1));
        run_block(1'b0, K2, P2, C2, -1, 1'b0, 0, "after_reset");

        run_block(1'b0, K2, P2, C2, -1, 1'b1, 0, "flush_accept");
        run_block(1'b1, K2, C2, P2, 4, 1'b0, 0, "flush_round");
        run_block(1'b0, K2, P2, C2, 3, 1'b0, 0, "flush_expand");
        run_block(1'b1, K2, C2, P2, -1, 1'b0, 0, "after_exp_flush");

        for (int n = 0; n < 10; n++) begin
            pick = $urandom_range(0, 2);
            rk = (pick == 0) ? K1 : (pick == 1) ? K2 : {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            rm = 1'($urandom_range(0, 1));
            run_block(rm, rk, rd, aes_model(rk, rd, rm), -1, 1'b0, $urandom_range(0, 2), "rand");
        end

        sel = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run_block(1'b0, K1, P1, C1, -1, 1'b0, 0, "nocache_a");
        run_block(1'b1, K1, C1, P1, -1, 1'b0, 1, "nocache_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
